dmem_responder: RTL and testbench

//  Memory-side responder for the CPU's MEM-stage data port. Serves word loads/stores

---
 rtl/dmem_responder_pkg.sv | 41 ++++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder and its array.
// Holds FSM state encodings, the latched-request record and a byte-merge helper.
package dmem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              err;
    } req_t;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] result;
        result = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word array: synchronous byte-enable write, combinational read,
// both on the same word index.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left without a reset; resetting a RAM
    // prevents mapping to memory macros and contents are don't-care at power-up.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= merge_bytes(mem[idx], wdata, be);
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one outstanding request,
// programmable wait states, range/alignment checking and response back-pressure.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              lat;
    logic [IDX_W-1:0]  lat_idx;

    logic [ADDR_W-3:0] in_idx;
    logic              in_err;
    req_t              in_req;
    req_t              cur;
    logic [IDX_W-1:0]  cur_idx;
    logic              accept;
    logic              retire;
    logic              commit;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    assign in_idx = req_addr[ADDR_W-1:2];
    assign in_err = is_misaligned(req_addr[1:0]) || (in_idx >= (ADDR_W-2)'(DEPTH));
    assign in_req = '{we: req_we, be: req_be, wdata: req_wdata, err: in_err};

    assign accept = (state == S_IDLE) && req_valid && req_ready;
    assign retire = (state == S_RESP) && rsp_valid && rsp_ready;

    // With zero wait states the commit edge is the accept edge, so the array
    // must see the live request rather than the latched copy.
    assign commit = (accept && (WAIT_CYCLES == 0)) ||
                    ((state == S_WAIT) && (cnt == CNT_ONE));

    always_comb begin
        cur     = lat;
        cur_idx = lat_idx;
        if (state == S_IDLE) begin
            cur     = in_req;
            cur_idx = in_idx[IDX_W-1:0];
        end
    end

    assign wr_en = commit && cur.we && !cur.err;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .idx   (cur_idx),
        .be    (cur.be),
        .wdata (cur.wdata),
        .rdata (rd_data)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat       <= '0;
            lat_idx   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat       <= in_req;
                        lat_idx   <= in_idx[IDX_W-1:0];
                        cnt       <= WAIT_LD;
                        req_ready <= 1'b0;
                        state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_ONE) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_RESP: begin
                    // rsp_valid is registered, so it rises one cycle after the
                    // commit edge: accept-to-valid is WAIT_CYCLES+1 edges.
                    if (retire) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (commit) begin
                rsp_rdata <= (cur.we || cur.err) ? '0 : rd_data;
                rsp_err   <= cur.err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with WAIT_CYCLES=2:
// reset, store/load, byte enables, errors, back-pressure and reset mid-WAIT.
module tb_dmem_responder;

    localparam int DEPTH       = 1024;
    localparam int ADDR_W      = 32;
    localparam int WAIT_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [3:0]        req_be = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction. Request fields are scrambled while the responder
    // is busy; hold > 0 keeps rsp_ready low for that many cycles.
    task automatic do_req(
        input string       tag,
        input logic        we,
        input logic [31:0] addr,
        input logic [3:0]  be,
        input logic [31:0] wdata,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input int          hold
    );
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_we    = ~we;
        req_addr  = 32'h0000_0040;
        req_be    = ~be;
        req_wdata = ~wdata;
        lat = 0;
        @(negedge clk);
        check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check({tag, "_rsp_timeout"}, {31'b0, rsp_valid}, 32'd1);
        req_valid = 1'b0;
        check({tag, "_latency"}, lat, 32'd3);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, "_bp_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "_bp_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_be    = 4'($urandom);
            req_wdata = $urandom;
            rsp_ready = 1'($urandom);
            @(negedge clk);
            check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("release_req_ready", {31'b0, req_ready}, 32'd1);

        do_req("st_beef", 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        do_req("ld_beef", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        do_req("st_be0", 1'b1, 32'h10, 4'h0, 32'h9999_9999, 32'h0, 1'b0, 0);
        do_req("ld_be0", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        do_req("st_full", 1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 0);
        do_req("st_part", 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, 0);
        do_req("ld_part", 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, 0);

        do_req("ld_misal", 1'b0, 32'h22, 4'hF, 32'h0, 32'h0, 1'b1, 0);
        do_req("st_zero", 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        do_req("st_range", 1'b1, DEPTH * 4, 4'hF, 32'h1234_5678, 32'h0, 1'b1, 0);
        do_req("ld_zero", 1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
        do_req("st_last", 1'b1, DEPTH * 4 - 4, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0, 0);
        do_req("ld_last", 1'b0, DEPTH * 4 - 4, 4'hF, 32'h0, 32'hA5A5_5A5A, 1'b0, 0);

        do_req("ld_bp", 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, 5);

        do_req("st_prev", 1'b1, 32'h30, 4'hF, 32'h1020_3040, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_be    = 4'hF;
        req_wdata = 32'h0000_0055;
        check("rstw_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_in_reset", {31'b0, rsp_valid}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw_after", {31'b0, rsp_valid}, 32'd0);
        end
        do_req("ld_prev", 1'b0, 32'h30, 4'hF, 32'h0, 32'h1020_3040, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
